// File: rtl/dbg_slave_pkg.sv
// -----------------------------------------------------------------------------
// dbg_slave_pkg
// Shared types and defaults for the system-clock side of the Nios II JTAG debug
// slave command queue.
//   DBG_SR_W / DBG_IR_W / DBG_ACT_BIT : default widths and the action-select bit
//   dbg_cmd_t                         : one captured command {ir, data}
//   onehot_ir()                       : IR value -> one-hot strobe channel vector
// The queue entry type is sized from these defaults, so a top-level override
// of SR_W / IR_W must be matched here.
// -----------------------------------------------------------------------------
package dbg_slave_pkg;

    localparam int DBG_SR_W    = 38;
    localparam int DBG_IR_W    = 2;
    localparam int DBG_ACT_BIT = 34;
    localparam int DBG_N_CMD   = 2 ** DBG_IR_W;

    typedef struct packed {
        logic [DBG_IR_W-1:0] ir;
        logic [DBG_SR_W-1:0] data;
    } dbg_cmd_t;

    function automatic logic [DBG_N_CMD-1:0] onehot_ir(input logic [DBG_IR_W-1:0] ir);
        logic [DBG_N_CMD-1:0] v;
        v     = '0;
        v[ir] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/nios_dbg_sysclk_cmd_queue_if.sv
// -----------------------------------------------------------------------------
// nios_dbg_sysclk_cmd_queue_if
// Command hand-off between the queue (master) and the debug core (slave).
//   cmd_valid : queue non-empty, head command presented on cmd_ir / jdo
//   cmd_ready : consumer accepts the head this cycle
//   cmd_ir    : head command IR
//   jdo       : head command data
// Handshake: a transfer (pop) happens on a clk edge where cmd_valid and
// cmd_ready are both high. cmd_valid never depends on cmd_ready; cmd_ready
// while cmd_valid is low has no effect; cmd_ir / jdo are stable while
// cmd_valid is high and not yet accepted.
// -----------------------------------------------------------------------------
interface nios_dbg_sysclk_cmd_queue_if #(
    parameter int IR_W = 2,
    parameter int SR_W = 38
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [SR_W-1:0] jdo;

    modport master (output cmd_valid, output cmd_ir, output jdo, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_ir, input jdo, output cmd_ready);
endinterface

// File: rtl/dbg_sync_edge_det.sv
// -----------------------------------------------------------------------------
// dbg_sync_edge_det
// Brings an asynchronous TCK-domain level into clk and emits a single-cycle
// registered pulse for each rising edge, however long the level stays high.
// The pulse is high during the cycle after the SYNC_STAGES+1'th clk edge that
// follows the input's rise.
//   clk      : system clock
//   reset_n  : asynchronous reset, active low (chain and pulse cleared)
//   async_in : asynchronous level
//   pulse    : one-cycle rising-edge strobe
// -----------------------------------------------------------------------------
module dbg_sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            pulse  <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/nios_dbg_sysclk_cmd_queue.sv
// -----------------------------------------------------------------------------
// nios_dbg_sysclk_cmd_queue
// System-clock side of the Nios II JTAG debug slave. Update-DR / update-IR
// events from TCK are synchronised into clk; each update-DR captures
// {ir_in, sr} into a small command queue whose head is handed to the debug
// core over cmd_if. Every pop is decoded into a one-hot take_action or
// take_no_action strobe. A command arriving at a full queue (with no pop in
// the same cycle) is dropped and sets the sticky overrun flag.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   vs_udr, vs_uir      : asynchronous TCK-domain update-DR / update-IR levels
//   ir_in, sr           : TCK-domain IR and shift register (held stable by source)
//   cmd_if (master)     : cmd_valid / cmd_ready / cmd_ir / jdo
//   clr_overrun         : synchronous clear of overrun
//   take_action         : one-hot pulse on pop when jdo[ACT_BIT] = 1
//   take_no_action      : one-hot pulse on pop when jdo[ACT_BIT] = 0
//   ir_update, ir_sync  : update-IR strobe and the IR captured with it
//   overrun             : sticky dropped-command flag
//   fifo_level          : occupied queue entries
// -----------------------------------------------------------------------------
module nios_dbg_sysclk_cmd_queue
    import dbg_slave_pkg::*;
#(
    parameter  int SR_W        = DBG_SR_W,
    parameter  int IR_W        = DBG_IR_W,
    parameter  int ACT_BIT     = DBG_ACT_BIT,
    parameter  int SYNC_STAGES = 2,
    parameter  int FIFO_DEPTH  = 4,
    localparam int N_CMD       = 2 ** IR_W,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [SR_W-1:0]               sr,
    nios_dbg_sysclk_cmd_queue_if.master   cmd_if,
    input  logic                          clr_overrun,
    output logic [N_CMD-1:0]              take_action,
    output logic [N_CMD-1:0]              take_no_action,
    output logic                          ir_update,
    output logic [IR_W-1:0]               ir_sync,
    output logic                          overrun,
    output logic [LVL_W-1:0]              fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic udr_stb;
    logic uir_stb;

    dbg_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_udr),
        .pulse    (udr_stb)
    );

    dbg_sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_uir),
        .pulse    (uir_stb)
    );

    dbg_cmd_t         mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [LVL_W-1:0] level;
    logic             valid_q;
    dbg_cmd_t         head_q;

    dbg_cmd_t         new_cmd;
    logic             pop;
    logic             full;
    logic             push;
    logic             drop;
    logic [PTR_W-1:0] next_rd;
    logic [LVL_W-1:0] level_after_pop;
    logic [LVL_W-1:0] next_level;
    dbg_cmd_t         next_head;

    // ir_in / sr are a multicycle path: the TCK side holds them stable while
    // vs_udr is high, long enough for the synchronised strobe to sample them.
    assign new_cmd.ir   = ir_in;
    assign new_cmd.data = sr;

    assign pop  = valid_q & cmd_if.cmd_ready;
    assign full = (level == LVL_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign push = udr_stb & (~full | pop);
    assign drop = udr_stb & full & ~pop;

    assign next_rd         = rd_ptr + PTR_W'(pop);
    assign level_after_pop = level - LVL_W'(pop);
    assign next_level      = level_after_pop + LVL_W'(push);

    // The head register is reloaded every cycle the queue stays non-empty.
    // If the queue would be empty apart from this push, the new command is the
    // head; otherwise the entry at the (possibly advanced) read pointer is.
    assign next_head = (level_after_pop == '0) ? new_cmd : mem[next_rd];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_cmd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            valid_q   <= 1'b0;
            head_q    <= '0;
            overrun   <= 1'b0;
            ir_sync   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr  <= next_rd;
            level   <= next_level;
            valid_q <= (next_level != '0);
            // Last head is held once the queue drains.
            if (next_level != '0) begin
                head_q <= next_head;
            end
            // Set has priority over clear.
            overrun <= drop | (overrun & ~clr_overrun);
            if (uir_stb) begin
                ir_sync <= ir_in;
            end
        end
    end

    assign ir_update  = uir_stb;
    assign fifo_level = level;

    assign cmd_if.cmd_valid = valid_q;
    assign cmd_if.cmd_ir    = head_q.ir;
    assign cmd_if.jdo       = head_q.data;

    assign take_action    = (pop &  head_q.data[ACT_BIT]) ? onehot_ir(head_q.ir) : '0;
    assign take_no_action = (pop & ~head_q.data[ACT_BIT]) ? onehot_ir(head_q.ir) : '0;

endmodule

// File: tb/tb_nios_dbg_sysclk_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_nios_dbg_sysclk_cmd_queue
// Directed scenarios followed by randomized command traffic. A reference model
// tracks the queue as a plain list of {ir, data} commands, with TCK events
// taking effect a fixed number of clk edges after the source level rises.
// -----------------------------------------------------------------------------
module tb_nios_dbg_sysclk_cmd_queue;

    localparam int SR_W  = 38;
    localparam int IR_W  = 2;
    localparam int SYNC  = 2;
    localparam int DEPTH = 4;
    localparam int ACT   = 34;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic            vs_udr = 1'b0;
    logic            vs_uir = 1'b0;
    logic [IR_W-1:0] ir_in  = '0;
    logic [SR_W-1:0] sr     = '0;
    logic            clr_overrun = 1'b0;
    logic [3:0]      take_action;
    logic [3:0]      take_no_action;
    logic            ir_update;
    logic [IR_W-1:0] ir_sync;
    logic            overrun;
    logic [2:0]      fifo_level;

    nios_dbg_sysclk_cmd_queue_if #(.IR_W(IR_W), .SR_W(SR_W)) tb_if ();

    nios_dbg_sysclk_cmd_queue #(
        .SR_W(SR_W), .IR_W(IR_W), .ACT_BIT(ACT), .SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .vs_udr         (vs_udr),
        .vs_uir         (vs_uir),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_if         (tb_if),
        .clr_overrun    (clr_overrun),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .ir_update      (ir_update),
        .ir_sync        (ir_sync),
        .overrun        (overrun),
        .fifo_level     (fifo_level)
    );

    // ---------------- scoreboard ----------------
    int n_vectors = 0;
    int n_errors  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: exp_q holds {ir, data} for each queued command, head first.
    logic [IR_W+SR_W-1:0] exp_q[$];
    logic [IR_W+SR_W-1:0] udr_val = '0;
    logic [IR_W-1:0]      uir_val = '0;
    int                   udr_cnt = 0;
    int                   uir_cnt = 0;
    logic                 m_overrun   = 1'b0;
    logic                 m_ir_update = 1'b0;
    logic [IR_W-1:0]      m_ir_sync   = '0;

    always @(posedge clk) begin
        logic m_pop, m_full, fire, m_set;
        logic [IR_W+SR_W-1:0] hd;
        logic [3:0] exp_ta, exp_tna;
        if (!reset_n) begin
            exp_q.delete();
            udr_cnt     = 0;
            uir_cnt     = 0;
            m_overrun   = 1'b0;
            m_ir_update = 1'b0;
            m_ir_sync   = '0;
        end else begin
            m_pop  = (exp_q.size() != 0) && tb_if.cmd_ready;
            m_full = (exp_q.size() == DEPTH);
            if (m_ir_update) m_ir_sync = uir_val;
            m_ir_update = 1'b0;
            if (uir_cnt > 0) begin
                uir_cnt--;
                if (uir_cnt == 0) m_ir_update = 1'b1;
            end
            fire = 1'b0;
            if (udr_cnt > 0) begin
                udr_cnt--;
                if (udr_cnt == 0) fire = 1'b1;
            end
            m_set = 1'b0;
            if (m_pop) void'(exp_q.pop_front());
            if (fire) begin
                if (!m_full || m_pop) exp_q.push_back(udr_val);
                else m_set = 1'b1;
            end
            m_overrun = m_set | (m_overrun & ~clr_overrun);
        end
        #1;
        hd      = (exp_q.size() != 0) ? exp_q[0] : '0;
        exp_ta  = '0;
        exp_tna = '0;
        if (exp_q.size() != 0 && tb_if.cmd_ready) begin
            if (hd[ACT]) exp_ta[hd[IR_W+SR_W-1:SR_W]] = 1'b1;
            else         exp_tna[hd[IR_W+SR_W-1:SR_W]] = 1'b1;
        end
        check("cmd_valid", tb_if.cmd_valid, exp_q.size() != 0);
        check("fifo_level", fifo_level, exp_q.size());
        check("overrun", overrun, m_overrun);
        check("ir_update", ir_update, m_ir_update);
        check("ir_sync", ir_sync, m_ir_sync);
        check("take_action", take_action, exp_ta);
        check("take_no_action", take_no_action, exp_tna);
        if (exp_q.size() != 0) begin
            check("head", {tb_if.cmd_ir, tb_if.jdo}, hd);
        end
    end

    // ---------------- driver tasks ----------------
    logic rand_mode = 1'b0;

    task automatic tick();
        @(negedge clk);
        if (rand_mode) begin
            tb_if.cmd_ready = 1'($urandom_range(0, 1));
            clr_overrun     = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic udr_cmd(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] data, input int hold);
        ir_in   = ir;
        sr      = data;
        udr_val = {ir, data};
        udr_cnt = SYNC + 2;
        vs_udr  = 1'b1;
        repeat (hold) tick();
        vs_udr = 1'b0;
        repeat (5) tick();
    endtask

    task automatic uir_cmd(input logic [IR_W-1:0] ir, input int hold);
        ir_in   = ir;
        uir_val = ir;
        uir_cnt = SYNC + 1;
        vs_uir  = 1'b1;
        repeat (hold) tick();
        vs_uir = 1'b0;
        repeat (5) tick();
    endtask

    function automatic logic [SR_W-1:0] rand_data();
        return {6'($urandom), 32'($urandom)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [SR_W-1:0] sent [5];
        logic [SR_W-1:0] d;
        int n, pulses;
        logic [2:0] lvl_before;

        tb_if.cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", tb_if.cmd_valid, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_ir_sync", ir_sync, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: single action command, cmd_valid on the 4th edge after the rise
        ir_in   = 2'd2;
        sr      = 38'h4_0000_0ABC;
        udr_val = {2'd2, 38'h4_0000_0ABC};
        udr_cnt = SYNC + 2;
        vs_udr  = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #2;
            check($sformatf("t1_valid_e%0d", e), tb_if.cmd_valid, (e == 4));
        end
        @(negedge clk);
        vs_udr = 1'b0;
        check("t1_jdo", tb_if.jdo, 38'h4_0000_0ABC);
        tb_if.cmd_ready = 1'b1;
        #1;
        check("t1_take_action", take_action, 4'b0100);
        check("t1_take_no_action", take_no_action, 4'b0000);
        @(negedge clk);
        check("t1_ta_done", take_action, 4'b0000);
        repeat (4) tick();

        // 2: no-action command with the consumer already ready
        d = rand_data();
        d[ACT] = 1'b0;
        udr_cmd(2'd0, d, 2);
        check("t2_level", fifo_level, 3'd0);
        tb_if.cmd_ready = 1'b0;

        // 3: overflow, then drain in order
        for (int i = 0; i < 5; i++) begin
            sent[i] = rand_data();
            udr_cmd(2'($urandom), sent[i], 1 + i % 3);
        end
        check("t3_level", fifo_level, 3'd4);
        check("t3_overrun", overrun, 1'b1);
        tb_if.cmd_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 7; c++) begin
            #1;
            if (tb_if.cmd_valid && n < 5) begin
                check("t3_drain", tb_if.jdo, sent[n]);
                n++;
            end
            @(negedge clk);
        end
        check("t3_pops", n, 4);
        tb_if.cmd_ready = 1'b0;
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("t3_overrun_clr", overrun, 1'b0);

        // 4: push coincident with pop at full
        for (int i = 0; i < 4; i++) udr_cmd(2'($urandom), rand_data(), 2);
        check("t4_full", fifo_level, 3'd4);
        ir_in   = 2'd1;
        sr      = rand_data();
        udr_val = {2'd1, sr};
        udr_cnt = SYNC + 2;
        vs_udr  = 1'b1;
        repeat (3) @(negedge clk);
        tb_if.cmd_ready = 1'b1;
        @(negedge clk);
        tb_if.cmd_ready = 1'b0;
        vs_udr = 1'b0;
        check("t4_level", fifo_level, 3'd4);
        check("t4_overrun", overrun, 1'b0);
        repeat (5) tick();

        // 5: long update-IR pulse gives exactly one strobe
        lvl_before = fifo_level;
        ir_in   = 2'd3;
        uir_val = 2'd3;
        uir_cnt = SYNC + 1;
        vs_uir  = 1'b1;
        pulses  = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 9) vs_uir = 1'b0;
            if (ir_update) pulses++;
        end
        check("t5_pulses", pulses, 1);
        check("t5_ir_sync", ir_sync, 2'd3);
        check("t5_level", fifo_level, lvl_before);

        // 6: reset mid-drain with level 3 and overrun set
        udr_cmd(2'd2, rand_data(), 2);
        check("t6_overrun_set", overrun, 1'b1);
        tb_if.cmd_ready = 1'b1;
        @(negedge clk);
        tb_if.cmd_ready = 1'b0;
        check("t6_level3", fifo_level, 3'd3);
        @(negedge clk);
        tb_if.cmd_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", tb_if.cmd_valid, 1'b0);
        check("t6_rst_level", fifo_level, 3'd0);
        check("t6_rst_overrun", overrun, 1'b0);
        check("t6_rst_ta", take_action, 4'b0000);
        check("t6_rst_tna", take_no_action, 4'b0000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t6_post_strobes", {take_action, take_no_action}, 8'h00);
        end

        // random traffic
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 5) == 0) uir_cmd(2'($urandom), $urandom_range(1, 6));
            else udr_cmd(2'($urandom), rand_data(), $urandom_range(1, 4));
        end
        rand_mode = 1'b0;
        tb_if.cmd_ready = 1'b1;
        clr_overrun = 1'b0;
        repeat (8) @(negedge clk);
        check("final_level", fifo_level, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_errors);
        $finish;
    end

endmodule
